// File: rtl/poly_voice_controller_pkg.sv
// Shared types and constants for the polyphonic voice controller.
// Holds the envelope stage enum, the octave-0 half-period table and the note range.
package poly_voice_controller_pkg;

   localparam int NOTE_MAX = 11;
   localparam int HALF_W   = 16;

   typedef enum logic [2:0] {
      ENV_IDLE,
      ENV_ATTACK,
      ENV_DECAY,
      ENV_SUSTAIN,
      ENV_RELEASE
   } env_state_t;

   typedef logic [HALF_W-1:0] half_t;

   // Octave-0 square half-periods in clocks, C through B, for a 1 MHz clock.
   localparam half_t BASE_HALF [0:11] = '{
      16'd30581, 16'd28868, 16'd27248, 16'd25707, 16'd24272, 16'd22904,
      16'd21626, 16'd20408, 16'd19260, 16'd18182, 16'd17159, 16'd16197
   };

   function automatic half_t half_period(input logic [3:0] note, input logic [2:0] octave);
      half_t base;
      base = (note <= 4'(NOTE_MAX)) ? BASE_HALF[note] : '0;
      return base >> octave;
   endfunction

endpackage

// File: rtl/poly_voice_controller_voice_channel.sv
// One synth voice: square-wave oscillator plus ADSR envelope state machine.
// The allocator in the top decides when a voice is loaded or released.
module voice_channel
   import poly_voice_controller_pkg::*;
#(
   parameter int ENV_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             load,
   input  logic             release_req,
   input  logic [6:0]       key_in,
   input  half_t            half_in,
   input  logic [ENV_W-1:0] peak_in,
   input  logic [ENV_W-1:0] attack,
   input  logic [ENV_W-1:0] decay,
   input  logic [ENV_W-1:0] sustain,
   input  logic [ENV_W-1:0] rel,
   output logic [6:0]       key,
   output logic [ENV_W-1:0] level,
   output logic             square,
   output logic             active
);

   env_state_t       state;
   half_t            half;
   half_t            phase;
   logic [ENV_W-1:0] peak;
   logic [ENV_W-1:0] rate_cnt;
   logic [ENV_W-1:0] cur_rate;
   logic [ENV_W-1:0] decay_floor;
   logic             step;

   always_comb begin
      cur_rate = '0;
      case (state)
         ENV_ATTACK:  cur_rate = attack;
         ENV_DECAY:   cur_rate = decay;
         ENV_RELEASE: cur_rate = rel;
         default:     cur_rate = '0;
      endcase
   end

   // A stage of rate r steps once every r+1 ticks.
   assign step        = tick && (rate_cnt == cur_rate);
   assign decay_floor = (sustain < peak) ? sustain : peak;
   assign active      = (state != ENV_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ENV_IDLE;
         key      <= '0;
         half     <= '0;
         phase    <= '0;
         peak     <= '0;
         level    <= '0;
         square   <= 1'b0;
         rate_cnt <= '0;
      end else if (load) begin
         state    <= ENV_ATTACK;
         key      <= key_in;
         half     <= half_in;
         phase    <= '0;
         peak     <= peak_in;
         level    <= '0;
         square   <= 1'b1;
         rate_cnt <= '0;
      end else begin
         if (state != ENV_IDLE) begin
            if (phase == half - half_t'(1)) begin
               phase  <= '0;
               square <= ~square;
            end else begin
               phase <= phase + half_t'(1);
            end
         end

         if (tick)
            rate_cnt <= step ? '0 : rate_cnt + ENV_W'(1);

         // Stage changes restart the rate counter so each stage times from its own entry.
         if (release_req && state != ENV_IDLE) begin
            state    <= ENV_RELEASE;
            rate_cnt <= '0;
         end else begin
            case (state)
               ENV_ATTACK:
                  if (level == peak) begin
                     state    <= ENV_DECAY;
                     rate_cnt <= '0;
                  end else if (step) begin
                     level <= level + ENV_W'(1);
                  end
               ENV_DECAY:
                  if (level <= decay_floor) begin
                     state    <= ENV_SUSTAIN;
                     rate_cnt <= '0;
                  end else if (step) begin
                     level <= level - ENV_W'(1);
                  end
               ENV_RELEASE:
                  if (level == '0) begin
                     state <= ENV_IDLE;
                  end else if (step) begin
                     level <= level - ENV_W'(1);
                  end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/poly_voice_controller.sv
// Polyphonic voice controller: note allocation with voice stealing, shared envelope
// prescaler and a saturating mixer over NUM_VOICES voice_channel instances.
module poly_voice_controller
   import poly_voice_controller_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int ENV_W      = 6,
   parameter int OUT_W      = 10,
   parameter int TICK_DIV   = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    note_on,
   input  logic                    note_off,
   input  logic [3:0]              note,
   input  logic [2:0]              octave,
   input  logic [ENV_W-1:0]        amplitude,
   input  logic [ENV_W-1:0]        attack,
   input  logic [ENV_W-1:0]        decay,
   input  logic [ENV_W-1:0]        sustain,
   input  logic [ENV_W-1:0]        rel,
   output logic signed [OUT_W-1:0] wave_out,
   output logic [NUM_VOICES-1:0]   voice_active,
   output logic                    stolen,
   output logic                    bad_note
);

   localparam int PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int OUT_MAX = (1 <<< (OUT_W - 1)) - 1;
   localparam int OUT_MIN = -(1 <<< (OUT_W - 1));

   logic [PRE_W-1:0]      prescale;
   logic                  tick;
   logic                  note_valid;
   logic                  do_on;
   logic                  do_off;
   logic [6:0]            key_req;
   half_t                 half_req;
   logic [2:0]            steal_ptr;
   logic [2:0]            hit_idx;
   logic [2:0]            free_idx;
   logic [2:0]            alloc_idx;
   logic                  hit;
   logic                  free;
   logic                  steal;
   logic [NUM_VOICES-1:0] load_v;
   logic [NUM_VOICES-1:0] release_v;
   logic [NUM_VOICES-1:0] square_v;
   logic [6:0]            key_v   [NUM_VOICES];
   logic [ENV_W-1:0]      level_v [NUM_VOICES];
   int                    mix_sum;
   logic signed [OUT_W-1:0] mix_sat;

   assign tick       = (prescale == PRE_W'(TICK_DIV - 1));
   assign note_valid = (note <= 4'(NOTE_MAX));
   assign do_on      = note_on && note_valid;
   assign do_off     = note_off && note_valid;
   assign key_req    = {note, octave};
   assign half_req   = half_period(note, octave);

   // Allocation priority: retrigger same key, else lowest idle voice, else steal.
   // A coincident note_off only moves voices to RELEASE, which never changes this choice.
   always_comb begin
      hit      = 1'b0;
      hit_idx  = '0;
      free     = 1'b0;
      free_idx = '0;
      for (int i = NUM_VOICES - 1; i >= 0; i--) begin
         if (voice_active[i] && key_v[i] == key_req) begin
            hit     = 1'b1;
            hit_idx = 3'(i);
         end
         if (!voice_active[i]) begin
            free     = 1'b1;
            free_idx = 3'(i);
         end
      end
      steal     = !hit && !free;
      alloc_idx = hit ? hit_idx : (free ? free_idx : steal_ptr);
      load_v    = '0;
      release_v = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         load_v[i]    = do_on && (alloc_idx == 3'(i));
         release_v[i] = do_off && voice_active[i] && (key_v[i] == key_req);
      end
   end

   for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
      voice_channel #(
         .ENV_W(ENV_W)
      ) u_voice (
         .clk        (clk),
         .reset      (reset),
         .tick       (tick),
         .load       (load_v[g]),
         .release_req(release_v[g]),
         .key_in     (key_req),
         .half_in    (half_req),
         .peak_in    (amplitude),
         .attack     (attack),
         .decay      (decay),
         .sustain    (sustain),
         .rel        (rel),
         .key        (key_v[g]),
         .level      (level_v[g]),
         .square     (square_v[g]),
         .active     (voice_active[g])
      );
   end

   always_comb begin
      mix_sum = 0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (voice_active[i])
            mix_sum = mix_sum + (square_v[i] ? int'(level_v[i]) : -int'(level_v[i]));
      end
      if (mix_sum > OUT_MAX)
         mix_sat = OUT_W'(OUT_MAX);
      else if (mix_sum < OUT_MIN)
         mix_sat = OUT_W'(OUT_MIN);
      else
         mix_sat = OUT_W'(mix_sum);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prescale  <= '0;
         steal_ptr <= '0;
         stolen    <= 1'b0;
         bad_note  <= 1'b0;
         wave_out  <= '0;
      end else begin
         prescale <= tick ? '0 : prescale + PRE_W'(1);
         stolen   <= do_on && steal;
         bad_note <= (note_on || note_off) && !note_valid;
         wave_out <= mix_sat;
         if (do_on && steal)
            steal_ptr <= (steal_ptr == 3'(NUM_VOICES - 1)) ? '0 : steal_ptr + 3'd1;
      end
   end

endmodule

// File: tb/tb_poly_voice_controller.sv
// Scoreboard bench for poly_voice_controller: expectations are queued as stimulus is
// driven and popped against the DUT outputs sampled on the falling edge.
module tb_poly_voice_controller;

   localparam int NV = 4;
   localparam int EW = 6;
   localparam int OW = 8;
   localparam int TD = 8;
   localparam int A4_HALF = 18182 >> 4;

   logic clk = 1'b0;
   logic reset;
   logic note_on;
   logic note_off;
   logic [3:0] note;
   logic [2:0] octave;
   logic [EW-1:0] amplitude;
   logic [EW-1:0] attack;
   logic [EW-1:0] decay;
   logic [EW-1:0] sustain;
   logic [EW-1:0] rel;
   logic signed [OW-1:0] wave_out;
   logic [NV-1:0] voice_active;
   logic stolen;
   logic bad_note;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string tag;
      int    value;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   poly_voice_controller #(
      .NUM_VOICES(NV),
      .ENV_W     (EW),
      .OUT_W     (OW),
      .TICK_DIV  (TD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .note_on     (note_on),
      .note_off    (note_off),
      .note        (note),
      .octave      (octave),
      .amplitude   (amplitude),
      .attack      (attack),
      .decay       (decay),
      .sustain     (sustain),
      .rel         (rel),
      .wave_out    (wave_out),
      .voice_active(voice_active),
      .stolen      (stolen),
      .bad_note    (bad_note)
   );

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks++;
      if (observed != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic expectValue(input string tag, input int value);
      exp_t e;
      e.tag   = tag;
      e.value = value;
      sb.push_back(e);
   endtask

   task automatic sampleOutput(input int observed);
      exp_t e;
      if (sb.size() == 0) begin
         checkOutput("sb_underflow", sb.size(), 1);
      end else begin
         e = sb.pop_front();
         checkOutput(e.tag, observed, e.value);
      end
   endtask

   function automatic int mag(input int v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic applyStimulus(input logic on, input logic off, input logic [3:0] n,
                                input logic [2:0] o, input logic [EW-1:0] amp);
      @(negedge clk);
      note_on   = on;
      note_off  = off;
      note      = n;
      octave    = o;
      amplitude = amp;
      @(negedge clk);
      note_on  = 1'b0;
      note_off = 1'b0;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic measureHalf(output int cycles);
      logic s0;
      s0 = wave_out[OW-1];
      cycles = 0;
      while (wave_out[OW-1] == s0 && cycles < 3000) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic checkIdleOutputs(input string tag);
      expectValue({tag, "_wave"}, 0);
      expectValue({tag, "_active"}, 0);
      expectValue({tag, "_stolen"}, 0);
      expectValue({tag, "_bad"}, 0);
      sampleOutput(wave_out);
      sampleOutput(int'(voice_active));
      sampleOutput(int'(stolen));
      sampleOutput(int'(bad_note));
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int h0, h1, h2;
      reset     = 1'b1;
      note_on   = 1'b0;
      note_off  = 1'b0;
      note      = '0;
      octave    = '0;
      amplitude = '0;
      attack    = '0;
      decay     = '0;
      sustain   = 6'd63;
      rel       = '0;
      waitCycles(3);
      reset = 1'b0;
      checkIdleOutputs("reset");

      // Single voice: attack ramp, sustain at peak, oscillator period.
      applyStimulus(1'b1, 1'b0, 4'd9, 3'd4, 6'd32);
      expectValue("first_voice_active", 1);
      sampleOutput(int'(voice_active));
      waitCycles(16 * TD);
      expectValue("attack_mid_14_18", 1);
      sampleOutput(int'(mag(wave_out) inside {[14:18]}));
      waitCycles(24 * TD);
      expectValue("attack_peak", 32);
      sampleOutput(mag(wave_out));
      measureHalf(h0);
      measureHalf(h1);
      measureHalf(h2);
      expectValue("square_half", A4_HALF);
      sampleOutput(h1);
      expectValue("square_period", 2 * A4_HALF);
      sampleOutput(h1 + h2);

      // Retrigger of the same key reuses voice 0 and restarts the level.
      applyStimulus(1'b1, 1'b0, 4'd9, 3'd4, 6'd32);
      expectValue("retrig_stolen", 0);
      expectValue("retrig_active", 1);
      sampleOutput(int'(stolen));
      sampleOutput(int'(voice_active));
      waitCycles(1);
      expectValue("retrig_level0", 0);
      sampleOutput(wave_out);
      waitCycles(8 * TD);
      expectValue("retrig_rise_6_10", 1);
      sampleOutput(int'(mag(wave_out) inside {[6:10]}));

      // Coincident off+on of the same key: off first, then the note retriggers.
      waitCycles(40 * TD);
      applyStimulus(1'b1, 1'b1, 4'd9, 3'd4, 6'd32);
      waitCycles(1);
      expectValue("offon_level0", 0);
      sampleOutput(wave_out);
      waitCycles(3 * TD);
      expectValue("offon_still_attack", 1);
      sampleOutput(int'(voice_active == 4'b0001 && mag(wave_out) inside {[1:4]}));
      waitCycles(40 * TD);
      expectValue("offon_sustain", 32);
      sampleOutput(mag(wave_out));

      // Release: unmatched key has no effect, matched key decays one step per tick.
      applyStimulus(1'b0, 1'b1, 4'd9, 3'd3, 6'd0);
      waitCycles(2 * TD);
      expectValue("off_nomatch", 32);
      sampleOutput(mag(wave_out));
      applyStimulus(1'b0, 1'b1, 4'd9, 3'd4, 6'd0);
      waitCycles(16 * TD);
      expectValue("release_mid_14_18", 1);
      sampleOutput(int'(mag(wave_out) inside {[14:18]}));
      waitCycles(12 * TD);
      expectValue("release_still_active", 1);
      sampleOutput(int'(voice_active));
      waitCycles(8 * TD);
      expectValue("release_idle", 0);
      sampleOutput(int'(voice_active));

      // Invalid notes pulse bad_note for one cycle and allocate nothing.
      applyStimulus(1'b1, 1'b0, 4'd13, 3'd2, 6'd40);
      expectValue("bad_on_pulse", 1);
      expectValue("bad_on_active", 0);
      sampleOutput(int'(bad_note));
      sampleOutput(int'(voice_active));
      waitCycles(1);
      expectValue("bad_pulse_end", 0);
      sampleOutput(int'(bad_note));
      applyStimulus(1'b0, 1'b1, 4'd15, 3'd0, 6'd0);
      expectValue("bad_off_pulse", 1);
      sampleOutput(int'(bad_note));

      // Fill all voices, then steal voice 0 and later voice 1.
      for (int k = 0; k < 4; k++) begin
         logic [3:0] nn;
         nn = (k == 3) ? 4'd5 : 4'(2 * k);
         applyStimulus(1'b1, 1'b0, nn, 3'd3, 6'd40);
         expectValue("fill_stolen", 0);
         sampleOutput(int'(stolen));
      end
      expectValue("fill_active", 15);
      sampleOutput(int'(voice_active));
      applyStimulus(1'b1, 1'b0, 4'd7, 3'd3, 6'd40);
      expectValue("steal_pulse", 1);
      sampleOutput(int'(stolen));
      waitCycles(1);
      expectValue("steal_pulse_end", 0);
      sampleOutput(int'(stolen));
      applyStimulus(1'b0, 1'b1, 4'd7, 3'd3, 6'd0);
      waitCycles(4 * TD);
      expectValue("steal_went_to_v0", 14);
      sampleOutput(int'(voice_active));
      applyStimulus(1'b1, 1'b0, 4'd9, 3'd3, 6'd40);
      expectValue("refill_no_steal", 0);
      sampleOutput(int'(stolen));
      applyStimulus(1'b1, 1'b0, 4'd11, 3'd3, 6'd40);
      expectValue("steal2_pulse", 1);
      sampleOutput(int'(stolen));
      applyStimulus(1'b0, 1'b1, 4'd11, 3'd3, 6'd0);
      waitCycles(4 * TD);
      expectValue("steal_ptr_v1", 13);
      sampleOutput(int'(voice_active));

      // Saturation: four full-scale voices whose squares line up in known windows.
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkIdleOutputs("reset2");
      for (int k = 4; k < 8; k++)
         applyStimulus(1'b1, 1'b0, 4'd9, 3'(k), 6'd63);
      waitCycles(2194);
      expectValue("sat_all_active", 15);
      sampleOutput(int'(voice_active));
      expectValue("sat_negative", -128);
      sampleOutput(wave_out);
      waitCycles(150);
      expectValue("sat_positive", 127);
      sampleOutput(wave_out);

      // Reset wins over coincident strobes, valid or invalid.
      @(negedge clk);
      reset    = 1'b1;
      note_on  = 1'b1;
      note     = 4'd2;
      octave   = 3'd1;
      @(negedge clk);
      note     = 4'd14;
      @(negedge clk);
      reset    = 1'b0;
      note_on  = 1'b0;
      checkIdleOutputs("reset_mid");
      waitCycles(2);
      checkIdleOutputs("reset_after");

      checkOutput("sb_drain", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/poly_voice_controller.md
POLY_VOICE_CONTROLLER -- requirements
Module: poly_voice_controller

Interface
REQ-001 Parameter NUM_VOICES, 4, number of simultaneous voices (1..8) SHALL be supported.
REQ-002 Parameter ENV_W, 6, envelope/amplitude width SHALL be supported.
REQ-003 Parameter OUT_W, 10, signed mixed-output width SHALL be supported.
REQ-004 Parameter TICK_DIV, 1024, clocks per envelope tick SHALL be supported.
REQ-005 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 note_on  in  1  one-cycle key-press strobe.
REQ-008 note_off  in  1  one-cycle key-release strobe.
REQ-009 note  in  4  pitch class 0..11; values 12..15 are invalid.
REQ-010 octave  in  3  octave 0..7.
REQ-011 amplitude  in  ENV_W  peak level, sampled at note_on.
REQ-012 attack, decay, sustain, rel  in  ENV_W each  ADSR rates/level, sampled live.
REQ-013 wave_out  out  OUT_W  signed two's-complement mixed sample, registered.
REQ-014 voice_active  out  NUM_VOICES  bit i high while voice i is not IDLE.
REQ-015 stolen  out  1  one-cycle pulse when note_on reallocates a busy voice.
REQ-016 bad_note  out  1  one-cycle pulse when note_on/note_off carries note>11.

Function
REQ-017 Each voice SHALL hold key {note,octave}, half-period, peak, phase counter, square bit, envelope FSM and ENV_W level.
REQ-018 Envelope FSM states: IDLE, ATTACK, DECAY, SUSTAIN, RELEASE.
REQ-019 One tick = TICK_DIV clocks from a shared free-running prescaler; a stage of rate r SHALL step level once every r+1 ticks.
REQ-020 ATTACK: level +1 per step until level==peak -> DECAY; DECAY: level -1 per step until level<=min(sustain,peak) -> SUSTAIN; SUSTAIN holds; RELEASE: level -1 per step until 0 -> IDLE.
REQ-021 Allocation on valid note_on, priority order: (a) voice with same key not IDLE -> retrigger; (b) lowest-index IDLE voice; (c) voice at steal pointer, pulse stolen, pointer increments mod NUM_VOICES.
REQ-022 Allocated voice SHALL load key, half-period, peak=amplitude, level=0, phase=0, square=1, enter ATTACK the cycle after the strobe.
REQ-023 Valid note_off SHALL move every non-IDLE voice with matching key to RELEASE from its current level; no match -> no effect.
REQ-024 note_on and note_off in the same cycle: note_off SHALL be applied first, then note_on.
REQ-025 Invalid note: strobe ignored, bad_note pulsed next cycle, no voice state changes.
REQ-026 Phase counter SHALL toggle square when it reaches half-period-1, then wrap to 0.
REQ-027 Voice contribution = +level if square else -level; IDLE contributes 0.
REQ-028 wave_out SHALL be the sum of all contributions, saturated to [-(2^(OUT_W-1)), 2^(OUT_W-1)-1], registered: 1-cycle latency from voice state.
REQ-029 Half-period SHALL equal base period of note (octave 0) shifted right by octave.

Reset
REQ-030 reset SHALL force all voices IDLE, levels/phases/keys 0, prescaler 0, steal pointer 0, wave_out=0, voice_active=0, stolen=0, bad_note=0.
REQ-031 reset asserted mid-note SHALL take priority over any coincident strobe; strobes during reset are discarded.

Structure
REQ-032 A shared package SHALL hold the envelope state enum, the 12-entry base half-period table, NOTE_MAX=11.
REQ-033 One sub-module voice_channel (per-voice oscillator + envelope FSM) SHALL be instantiated NUM_VOICES times via generate; allocation, prescaler and mixer remain in the top.

Verification
REQ-034 note_on note=9 octave=4 amplitude=32 attack=0 -> voice 0 active, level reaches 32 after 32 ticks, square period = 2x table[9]>>4 clocks.
REQ-035 Four note_on with distinct keys, then fifth (NUM_VOICES=4) -> stolen pulses once, voice 0 reloaded, steal pointer=1.
REQ-036 Repeat note_on same key while active -> same voice retriggered, level restarts at 0, no second voice used.
REQ-037 note_off on sustaining voice, rel=0 -> level falls 1 per tick to 0, voice_active bit clears.
REQ-038 Four voices at level 63, square phase-aligned, OUT_W=8 -> wave_out saturates to 127/-128.
REQ-039 note=13 note_on -> bad_note pulse, voice_active unchanged; reset mid-attack -> all outputs 0 next cycle.
